// File: rtl/la_pkg.sv
// Shared types for the multi-channel sampler/trigger engine.
// Trigger config field layout per channel and the capture FSM encoding.
package la_pkg;

  localparam int TRIG_CFG_W = 5;

  // Bit order matches the per-channel slice of trig_cfg: [4]pos [3]neg [2]high [1]low [0]dc.
  typedef struct packed {
    logic pos;
    logic neg;
    logic high;
    logic low;
    logic dc;
  } trig_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } fsm_t;

endpackage

// File: rtl/ch_sample_slice.sv
// One analyser channel: comparator synchroniser, sample history, packing
// shift register and the channel's trigger term.
module ch_sample_slice
  import la_pkg::*;
#(
  parameter int SYNC_STG = 2,
  parameter int SPW      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wrt_smpl,
  input  logic             i_hist_vld,
  input  logic             i_ch_h,
  input  logic             i_ch_l,
  input  trig_cfg_t        i_cfg,
  output logic [2*SPW-1:0] o_word,
  output logic             o_term
);

  logic [SYNC_STG-1:0] r_sync_h;
  logic [SYNC_STG-1:0] r_sync_l;
  logic                r_prev_h;
  logic                r_prev_l;
  logic [2*SPW-1:0]    r_word;
  logic                w_hs;
  logic                w_ls;
  logic                w_pos;
  logic                w_neg;
  logic [2*SPW+1:0]    w_shift;

  assign w_hs = r_sync_h[SYNC_STG-1];
  assign w_ls = r_sync_l[SYNC_STG-1];

  // Wide concatenation keeps the shift legal even when SPW == 1.
  assign w_shift = {r_word, w_hs, w_ls};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_h <= '0;
      r_sync_l <= '0;
      r_prev_h <= 1'b0;
      r_prev_l <= 1'b0;
      r_word   <= '0;
    end else begin
      r_sync_h <= {r_sync_h[SYNC_STG-2:0], i_ch_h};
      r_sync_l <= {r_sync_l[SYNC_STG-2:0], i_ch_l};
      if (i_wrt_smpl) begin
        r_prev_h <= w_hs;
        r_prev_l <= w_ls;
        r_word   <= w_shift[2*SPW-1:0];
      end
    end
  end

  // Edges need a real previous sample; before the first strobe they read as false.
  assign w_pos = i_hist_vld & w_hs & ~r_prev_h;
  assign w_neg = i_hist_vld & ~w_ls & r_prev_l;

  always_comb begin
    o_term = 1'b0;
    if (i_cfg.dc) begin
      o_term = 1'b1;
    end else if (i_cfg != '0) begin
      o_term = (~i_cfg.pos  | w_pos) &
               (~i_cfg.neg  | w_neg) &
               (~i_cfg.high | w_hs)  &
               (~i_cfg.low  | ~w_ls);
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/multi_ch_sample_trig.sv
// N-channel sampler and trigger engine between the AFE comparators and the
// capture RAM write logic: packs decimated samples and runs arm/trigger/post-count.
module multi_ch_sample_trig
  import la_pkg::*;
#(
  parameter int NUM_CH   = 5,
  parameter int SYNC_STG = 2,
  parameter int SPW      = 4,
  parameter int CNT_W    = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wrt_smpl,
  input  logic [NUM_CH-1:0]            CH_H,
  input  logic [NUM_CH-1:0]            CH_L,
  input  logic [TRIG_CFG_W*NUM_CH-1:0] trig_cfg,
  input  logic                         set_armed,
  input  logic                         clr_trig,
  input  logic [CNT_W-1:0]             post_cnt,
  output logic [2*SPW*NUM_CH-1:0]      smpl,
  output logic                         smpl_vld,
  output logic                         armed,
  output logic                         trig_det,
  output logic                         capt_done
);

  localparam int              PH_W    = (SPW > 1) ? $clog2(SPW) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SPW - 1);

  logic [PH_W-1:0]   r_phase;
  logic              r_smpl_vld;
  logic              r_hist_vld;
  logic [NUM_CH-1:0] w_terms;
  logic              w_trig_all;

  fsm_t              r_state;
  fsm_t              w_next_state;
  logic              w_fire;
  logic              w_cnt_inc;
  logic              r_trig_det;
  logic [CNT_W-1:0]  r_post_cnt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    trig_cfg_t w_cfg;
    assign w_cfg = trig_cfg[c*TRIG_CFG_W +: TRIG_CFG_W];

    ch_sample_slice #(
      .SYNC_STG (SYNC_STG),
      .SPW      (SPW)
    ) u_slice (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wrt_smpl (wrt_smpl),
      .i_hist_vld (r_hist_vld),
      .i_ch_h     (CH_H[c]),
      .i_ch_l     (CH_L[c]),
      .i_cfg      (w_cfg),
      .o_word     (smpl[c*2*SPW +: 2*SPW]),
      .o_term     (w_terms[c])
    );
  end

  assign w_trig_all = &w_terms;

  // Phase runs off the sample strobe alone so word framing survives arm/clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= '0;
      r_smpl_vld <= 1'b0;
      r_hist_vld <= 1'b0;
    end else begin
      r_smpl_vld <= wrt_smpl && (r_phase == PH_LAST);
      if (wrt_smpl) begin
        r_hist_vld <= 1'b1;
        r_phase    <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
      end
    end
  end

  // Abort wins over everything; a trigger in the same cycle as clr_trig is dropped.
  always_comb begin
    w_next_state = r_state;
    w_fire       = 1'b0;
    w_cnt_inc    = 1'b0;
    if (clr_trig) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (set_armed) w_next_state = ST_ARMED;
        end
        ST_ARMED: begin
          if (wrt_smpl && w_trig_all) begin
            w_next_state = ST_POST;
            w_fire       = 1'b1;
          end
        end
        ST_POST: begin
          if (wrt_smpl) begin
            if (r_post_cnt == post_cnt) w_next_state = ST_DONE;
            else                        w_cnt_inc    = 1'b1;
          end
        end
        ST_DONE: begin
          if (set_armed) w_next_state = ST_ARMED;
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_trig_det <= 1'b0;
      r_post_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_trig_det <= w_fire;
      if (w_fire)         r_post_cnt <= '0;
      else if (w_cnt_inc) r_post_cnt <= r_post_cnt + 1'b1;
    end
  end

  assign smpl_vld  = r_smpl_vld;
  assign trig_det  = r_trig_det;
  assign armed     = (r_state == ST_ARMED);
  assign capt_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_multi_ch_sample_trig.sv
// Directed bench for multi_ch_sample_trig: a 5-ch/SPW=4 instance and an
// 8-ch/SPW=2 instance driven in lockstep, checked through expected queues.
module tb_multi_ch_sample_trig;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        wrt_smpl;
  logic        set_armed;
  logic        clr_trig;
  logic [4:0]  ch_h;
  logic [4:0]  ch_l;
  logic [24:0] cfg_a;
  logic [8:0]  post_cnt;

  logic [7:0]  ch_h_b;
  logic [7:0]  ch_l_b;
  logic [39:0] cfg_b;
  assign ch_h_b = {3'b000, ch_h};
  assign ch_l_b = {3'b000, ch_l};
  assign cfg_b  = {15'b00001_00001_00001, cfg_a};

  logic [39:0] smpl_a;
  logic        vld_a, armed_a, trig_a, done_a;
  logic [31:0] smpl_b;
  logic        vld_b, armed_b, trig_b, done_b;

  multi_ch_sample_trig #(.NUM_CH(5), .SYNC_STG(2), .SPW(4), .CNT_W(9)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrt_smpl  (wrt_smpl),
    .CH_H      (ch_h),
    .CH_L      (ch_l),
    .trig_cfg  (cfg_a),
    .set_armed (set_armed),
    .clr_trig  (clr_trig),
    .post_cnt  (post_cnt),
    .smpl      (smpl_a),
    .smpl_vld  (vld_a),
    .armed     (armed_a),
    .trig_det  (trig_a),
    .capt_done (done_a)
  );

  multi_ch_sample_trig #(.NUM_CH(8), .SYNC_STG(2), .SPW(2), .CNT_W(9)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrt_smpl  (wrt_smpl),
    .CH_H      (ch_h_b),
    .CH_L      (ch_l_b),
    .trig_cfg  (cfg_b),
    .set_armed (set_armed),
    .clr_trig  (clr_trig),
    .post_cnt  (post_cnt),
    .smpl      (smpl_b),
    .smpl_vld  (vld_b),
    .armed     (armed_b),
    .trig_det  (trig_b),
    .capt_done (done_b)
  );

  // Scoreboard state
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic        smpl_chk_en = 1'b0;
  logic [39:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];
  int          trig_a_q[$];
  int          trig_b_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: pulse seen with nothing expected (cycle %0d)", nm, cyc);
  endtask

  task automatic chk_lvl(input string nm, input logic e_armed, input logic e_done);
    chk({nm, "_armed_a"}, 64'(armed_a), 64'(e_armed));
    chk({nm, "_armed_b"}, 64'(armed_b), 64'(e_armed));
    chk({nm, "_done_a"},  64'(done_a),  64'(e_done));
    chk({nm, "_done_b"},  64'(done_b),  64'(e_done));
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, "_smpl_a"}, 64'(smpl_a), 64'd0);
    chk({nm, "_smpl_b"}, 64'(smpl_b), 64'd0);
    chk({nm, "_vld"},    64'({vld_a, vld_b}), 64'd0);
    chk({nm, "_trig"},   64'({trig_a, trig_b}), 64'd0);
    chk_lvl(nm, 1'b0, 1'b0);
  endtask

  // Monitor: pops expectations whenever either DUT presents a pulse.
  initial begin
    int last_a = -1;
    int last_b = -1;
    forever begin
      @(negedge clk);
      if (vld_a && smpl_chk_en) begin
        if (exp_a_q.size() == 0) unexpected("smpl_a");
        else chk("smpl_a_word", 64'(smpl_a), 64'(exp_a_q.pop_front()));
        if (last_a >= 0) chk("smpl_a_period", 64'(cyc - last_a), 64'd8);
        last_a = cyc;
      end
      if (vld_b && smpl_chk_en) begin
        if (exp_b_q.size() == 0) unexpected("smpl_b");
        else chk("smpl_b_word", 64'(smpl_b), 64'(exp_b_q.pop_front()));
        if (last_b >= 0) chk("smpl_b_period", 64'(cyc - last_b), 64'd4);
        last_b = cyc;
      end
      if (trig_a) begin
        if (trig_a_q.size() == 0) unexpected("trig_det_a");
        else chk("trig_det_a_cycle", 64'(cyc), 64'(trig_a_q.pop_front()));
      end
      if (trig_b) begin
        if (trig_b_q.size() == 0) unexpected("trig_det_b");
        else chk("trig_det_b_cycle", 64'(cyc), 64'(trig_b_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic one_smpl(input logic [4:0] h, input logic [4:0] l, input bit exp_trig);
    @(negedge clk); ch_h = h; ch_l = l;
    @(negedge clk);
    @(negedge clk); wrt_smpl = 1'b1;
    if (exp_trig) begin
      trig_a_q.push_back(cyc + 1);
      trig_b_q.push_back(cyc + 1);
    end
    @(negedge clk); wrt_smpl = 1'b0;
  endtask

  task automatic arm();
    @(negedge clk); set_armed = 1'b1;
    @(negedge clk); set_armed = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk); clr_trig = 1'b1;
    @(negedge clk); clr_trig = 1'b0;
  endtask

  localparam logic [4:0]  DC = 5'b00001;
  localparam logic [24:0] ALL_DC = {DC, DC, DC, DC, DC};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [7:0] pat;
    rst_n = 1'b0; wrt_smpl = 1'b0; set_armed = 1'b0; clr_trig = 1'b0;
    ch_h = '0; ch_l = '0; cfg_a = ALL_DC; post_cnt = '0;
    repeat (3) @(negedge clk);
    chk_rst("por");
    rst_n = 1'b1;

    // 1: packing, ch0 H=1, ch4 L=1, ch1 H=L = 1,0,1,0,0,1,0,1; strobe every 2 clks
    pat = 8'b1010_0101;
    exp_a_q.push_back(40'h55_0000_CCAA);
    exp_a_q.push_back(40'h55_0000_33AA);
    exp_b_q.push_back(32'h0005_00CA);
    exp_b_q.push_back(32'h0005_00CA);
    exp_b_q.push_back(32'h0005_003A);
    exp_b_q.push_back(32'h0005_003A);
    smpl_chk_en = 1'b1;
    @(negedge clk);
    ch_h = {1'b0, 2'b00, pat[7], 1'b1};
    ch_l = {1'b1, 2'b00, pat[7], 1'b0};
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); wrt_smpl = 1'b1;
      if (i < 7) begin
        ch_h = {1'b0, 2'b00, pat[6-i], 1'b1};
        ch_l = {1'b1, 2'b00, pat[6-i], 1'b0};
      end
      @(negedge clk); wrt_smpl = 1'b0;
    end
    repeat (3) @(negedge clk);
    smpl_chk_en = 1'b0;
    chk("t1_words_left_a", 64'(exp_a_q.size()), 64'd0);
    chk("t1_words_left_b", 64'(exp_b_q.size()), 64'd0);

    // 2: ch2 pos-edge, post_cnt=3
    cfg_a = {DC, DC, 5'b10000, DC, DC};
    post_cnt = 9'd3;
    arm();
    chk_lvl("t2_arm", 1'b1, 1'b0);
    one_smpl(5'b00000, 5'b00000, 1'b0);
    chk_lvl("t2_no_edge", 1'b1, 1'b0);
    one_smpl(5'b00100, 5'b00000, 1'b1);
    chk_lvl("t2_post", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      one_smpl(5'b00100, 5'b00000, 1'b0);
      chk_lvl("t2_count", 1'b0, 1'b0);
    end
    one_smpl(5'b00100, 5'b00000, 1'b0);
    chk_lvl("t2_done", 1'b0, 1'b1);
    clr();
    chk_lvl("t2_clr", 1'b0, 1'b0);

    // 3: all dont-care triggers on first strobe; post_cnt=0; cfg=0 blocks
    cfg_a = ALL_DC;
    post_cnt = 9'd0;
    arm();
    one_smpl(5'b00000, 5'b00000, 1'b1);
    chk_lvl("t3_post", 1'b0, 1'b0);
    one_smpl(5'b00000, 5'b00000, 1'b0);
    chk_lvl("t3_done", 1'b0, 1'b1);
    arm();
    chk_lvl("t3_rearm", 1'b1, 1'b0);
    clr();
    cfg_a = {DC, 5'b00000, DC, DC, DC};
    arm();
    one_smpl(5'b11111, 5'b00000, 1'b0);
    one_smpl(5'b00000, 5'b11111, 1'b0);
    chk_lvl("t3_cfg0", 1'b1, 1'b0);
    clr();

    // 4: clr + set_armed + trigger in the same ARMED cycle
    cfg_a = ALL_DC;
    arm();
    @(negedge clk); wrt_smpl = 1'b1; clr_trig = 1'b1; set_armed = 1'b1;
    @(negedge clk); wrt_smpl = 1'b0; clr_trig = 1'b0; set_armed = 1'b0;
    chk_lvl("t4_clr", 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk_lvl("t4_hold", 1'b0, 1'b0);

    // 5: ch2 high out of reset, armed before the first strobe
    @(negedge clk); ch_h = 5'b00100; ch_l = 5'b00000; rst_n = 1'b0;
    @(negedge clk);
    chk_rst("t5_rst");
    cfg_a = {DC, DC, 5'b10000, DC, DC};
    post_cnt = 9'd100;
    @(negedge clk); rst_n = 1'b1;
    arm();
    one_smpl(5'b00100, 5'b00000, 1'b0);
    chk_lvl("t5_no_false", 1'b1, 1'b0);
    one_smpl(5'b00000, 5'b00000, 1'b0);
    one_smpl(5'b00100, 5'b00000, 1'b1);
    chk_lvl("t5_trig", 1'b0, 1'b0);

    // 6: asynchronous reset in POST
    one_smpl(5'b00100, 5'b00000, 1'b0);
    chk_lvl("t6_post", 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_rst("t6_async");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_lvl("t6_idle", 1'b0, 1'b0);

    chk("trig_left_a", 64'(trig_a_q.size()), 64'd0);
    chk("trig_left_b", 64'(trig_b_q.size()), 64'd0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
